// File: rtl/sb_rmw.sv
// Store unit that turns byte stores into a read-modify-write of the containing
// big-endian 32-bit word; word stores go straight to a single write.
module sb_rmw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        sbsel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  lane_reg;
  logic [1:0]  lane_next;
  logic [7:0]  byte_reg;
  logic [7:0]  byte_next;
  logic [29:0] mem_addr_next;
  logic [31:0] mem_wdata_next;
  logic        mem_re_next;
  logic        mem_we_next;
  logic        busy_next;
  logic        done_next;
  logic [31:0] merged;

  // Big-endian lane map: address offset 0 owns the most significant byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_SEL = 2'(3 - gi);
      assign merged[gi*8 +: 8] = (lane_reg == LANE_SEL) ? byte_reg
                                                         : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lane_reg  <= 2'b00;
      byte_reg  <= 8'h00;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      byte_reg  <= byte_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_re    <= mem_re_next;
      mem_we    <= mem_we_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lane_next      = lane_reg;
    byte_next      = byte_reg;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;

    case (state_reg)
      IDLE, DONE: begin
        if (req) begin
          mem_addr_next = addr[31:2];
          lane_next     = addr[1:0];
          byte_next     = wdata[7:0];
          // The chosen path itself records the store size.
          if (sbsel) begin
            state_next = RD;
          end else begin
            state_next     = WR;
            mem_wdata_next = wdata;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD:  state_next = MRG;
      MRG: begin
        mem_wdata_next = merged;
        state_next     = WR;
      end
      WR:      state_next = DONE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    mem_re_next = (state_next == RD);
    mem_we_next = (state_next == WR);
    busy_next   = (state_next == RD) || (state_next == MRG) || (state_next == WR);
    done_next   = (state_next == DONE);
  end

endmodule

// File: tb/tb_sb_rmw.sv
// Randomized and directed bench for sb_rmw against a word-array memory model
// and a shift/mask reference for the byte merge.
module tb_sb_rmw;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        sbsel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  sb_rmw dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sbsel     (sbsel),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int          cyc;
    logic [29:0] a;
    logic [31:0] d;
  } ev_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] mem [256];
  ev_t         we_q[$];
  ev_t         re_q[$];
  int          done_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    else        mem_rdata <= $urandom;
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
      e.cyc = cyc;
      e.a   = mem_addr;
      e.d   = mem_wdata;
      if (mem_we) we_q.push_back(e);
      if (mem_re) re_q.push_back(e);
      if (done)   done_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [1:0] lo,
                                            input logic [7:0] b);
    int sh;
    sh = (3 - int'(lo)) * 8;
    return (old & ~(32'h0000_00FF << sh)) | ({24'd0, b} << sh);
  endfunction

  task automatic clear_q();
    we_q.delete();
    re_q.delete();
    done_q.delete();
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_store(input bit sb, input logic [31:0] a, input logic [31:0] d,
                           input bit drop);
    logic [31:0] expw;
    int          c0;
    int          dn;
    clear_q();
    expw  = sb ? merge_ref(mem[a[9:2]], a[1:0], d[7:0]) : d;
    dn    = sb ? 4 : 2;
    c0    = cyc;
    req   = 1'b1;
    sbsel = sb;
    addr  = a;
    wdata = d;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req   = 1'b0;
        sbsel = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
      if (drop && sb && k == 2) req = 1'b1;
      if (k == 3) req = 1'b0;
      chk("busy", 32'(busy), 32'(k < dn));
      chk("done", 32'(done), 32'(k == dn));
    end
    chk("re_count", 32'(re_q.size()), sb ? 32'd1 : 32'd0);
    if (sb && re_q.size() == 1) begin
      chk("re_cycle", 32'(re_q[0].cyc - c0), 32'd1);
      chk("re_addr", 32'(re_q[0].a), 32'(a[31:2]));
    end
    chk("we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() == 1) begin
      chk("we_cycle", 32'(we_q[0].cyc - c0), sb ? 32'd3 : 32'd1);
      chk("we_addr", 32'(we_q[0].a), 32'(a[31:2]));
      chk("we_data", we_q[0].d, expw);
    end
    chk("done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1) chk("done_cycle", 32'(done_q[0] - c0), 32'(dn));
    chk("mem_addr_hold", 32'(mem_addr), 32'(a[31:2]));
    chk("mem_word", mem[a[9:2]], expw);
    $display("store sb=%0d addr=%h data=%h drop=%0d -> word %h", sb, a, d, drop, expw);
  endtask

  initial begin
    logic [31:0] lane_exp [4];
    logic [31:0] exp1;
    int          c0;
    lane_exp[0] = 32'h5AFF_FFFF;
    lane_exp[1] = 32'hFF5A_FFFF;
    lane_exp[2] = 32'hFFFF_5AFF;
    lane_exp[3] = 32'hFFFF_FF5A;
    rst_n = 1'b0;
    req   = 1'b0;
    sbsel = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] <= $urandom;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Middle-lane byte store.
    mem[4] <= 32'h1122_3344;
    @(negedge clk);
    run_store(1'b1, 32'h0000_0012, 32'h0000_00AB, 1'b0);
    chk("byte_mid_word", mem[4], 32'h1122_AB44);

    // Every lane of an all-ones word.
    for (int lo = 0; lo < 4; lo++) begin
      mem[5] <= 32'hFFFF_FFFF;
      @(negedge clk);
      run_store(1'b1, 32'h0000_0014 | 32'(lo), 32'h0000_005A, 1'b0);
      chk("lane_word", mem[5], lane_exp[lo]);
    end

    // Word store ignores the low address bits.
    run_store(1'b0, 32'h0000_0103, 32'hDEAD_BEEF, 1'b0);
    chk("word_store", mem[8'h40], 32'hDEAD_BEEF);

    // Request pulse during MRG must be dropped.
    run_store(1'b1, 32'h0000_0031, 32'h1234_56E7, 1'b1);

    // req held high: second request accepted in the DONE cycle.
    mem[9]  <= 32'h0102_0304;
    mem[10] <= 32'h0000_0000;
    @(negedge clk);
    clear_q();
    exp1  = merge_ref(mem[9], 2'b11, 8'hC3);
    c0    = cyc;
    req   = 1'b1;
    sbsel = 1'b1;
    addr  = 32'h0000_0027;
    wdata = 32'h0000_00C3;
    @(negedge clk);
    sbsel = 1'b0;
    addr  = 32'h0000_0028;
    wdata = 32'h89AB_CDEF;
    repeat (4) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_we_count", 32'(we_q.size()), 32'd2);
    if (we_q.size() == 2) begin
      chk("b2b_we0_cycle", 32'(we_q[0].cyc - c0), 32'd3);
      chk("b2b_we0_data", we_q[0].d, 32'h0102_03C3);
      chk("b2b_we1_cycle", 32'(we_q[1].cyc - c0), 32'd5);
      chk("b2b_we1_addr", 32'(we_q[1].a), 32'd10);
      chk("b2b_we1_data", we_q[1].d, 32'h89AB_CDEF);
    end
    chk("b2b_ref_merge", exp1, 32'h0102_03C3);
    chk("b2b_done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      chk("b2b_done0", 32'(done_q[0] - c0), 32'd4);
      chk("b2b_done1", 32'(done_q[1] - c0), 32'd6);
    end
    chk("b2b_re_count", 32'(re_q.size()), 32'd1);
    $display("back-to-back byte@0x27 then word@0x28 -> writes %0d", we_q.size());

    // Reset during MRG aborts the write.
    mem[8] <= 32'hCAFE_F00D;
    @(negedge clk);
    clear_q();
    req   = 1'b1;
    sbsel = 1'b1;
    addr  = 32'h0000_0021;
    wdata = 32'h0000_0077;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_re", 32'(mem_re), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(we_q.size()), 32'd0);
    chk("abort_mem_kept", mem[8], 32'hCAFE_F00D);
    $display("reset during MRG -> writes %0d", we_q.size());
    run_store(1'b0, 32'h0000_0200, 32'h1357_9BDF, 1'b0);

    // Randomized stores.
    for (int n = 0; n < 40; n++) begin
      run_store(1'($urandom), $urandom, $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
